// File: rtl/sysbus_pkg.sv
// Shared constants and the controller state type for the memory bus responder.
package sysbus_pkg;

    localparam int TAG_WR_BIT      = 12;
    localparam int BEATS_PER_BLOCK = 8;
    localparam int BLK_OFS_W       = 6;
    localparam int BEAT_W          = $clog2(BEATS_PER_BLOCK);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_WAIT = 2'd2,
        RD_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, one-cycle read latency, no reset on contents.
module mem_array #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Block-oriented bus responder: 8-beat writes and latency-delayed 8-beat reads
// against a local RAM.
//
// state   | meaning
// IDLE    | waiting for an address beat (blocked for one cycle after a transfer)
// WR_DATA | accepting the 8 write-data beats of the captured block
// RD_WAIT | counting down the read latency
// RD_RESP | presenting read beats, advancing on bus_respack
module mem_bus_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int RD_LATENCY     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack,
    output logic                      busy
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int BLK_W = IDX_W - BEAT_W;

    state_t                    state, state_nxt;
    logic [BLK_W-1:0]          blk, blk_nxt;
    logic [BUS_TAG_WIDTH-1:0]  tag, tag_nxt;
    logic [BEAT_W-1:0]         beat, beat_nxt;
    logic [3:0]                lat_cnt, lat_nxt;
    logic                      rearm, rearm_nxt;

    logic                      mem_we;
    logic [IDX_W-1:0]          mem_addr;
    logic [BUS_DATA_WIDTH-1:0] mem_rdata;
    logic [BLK_W-1:0]          req_blk;

    assign req_blk = bus_req[BLK_OFS_W +: BLK_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            blk     <= '0;
            tag     <= '0;
            beat    <= '0;
            lat_cnt <= '0;
            rearm   <= 1'b0;
        end else begin
            state   <= state_nxt;
            blk     <= blk_nxt;
            tag     <= tag_nxt;
            beat    <= beat_nxt;
            lat_cnt <= lat_nxt;
            rearm   <= rearm_nxt;
        end
    end

    // The RAM address always names the word to be shown on the next cycle,
    // so read data lines up with the state that presents it.
    always_comb begin
        state_nxt  = state;
        blk_nxt    = blk;
        tag_nxt    = tag;
        beat_nxt   = beat;
        lat_nxt    = lat_cnt;
        mem_we     = 1'b0;
        mem_addr   = {blk, beat};
        bus_reqack = 1'b0;

        unique case (state)
            IDLE: begin
                mem_addr = {req_blk, {BEAT_W{1'b0}}};
                if (bus_reqcyc && !rearm) begin
                    bus_reqack = 1'b1;
                    tag_nxt    = bus_reqtag;
                    blk_nxt    = req_blk;
                    beat_nxt   = '0;
                    if (bus_reqtag[TAG_WR_BIT]) begin
                        state_nxt = WR_DATA;
                    end else begin
                        lat_nxt   = 4'(RD_LATENCY);
                        state_nxt = (RD_LATENCY == 1) ? RD_RESP : RD_WAIT;
                    end
                end
            end
            WR_DATA: begin
                if (bus_reqcyc) begin
                    mem_we     = 1'b1;
                    bus_reqack = 1'b1;
                    beat_nxt   = beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        state_nxt = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                lat_nxt = lat_cnt - 4'd1;
                if (lat_cnt <= 4'd2) begin
                    state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                if (bus_respack) begin
                    beat_nxt = beat + 1'b1;
                    mem_addr = {blk, beat + 1'b1};
                    if (beat == LAST_BEAT) begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase

        rearm_nxt = (state != IDLE) && (state_nxt == IDLE);

        if (reset) begin
            mem_we     = 1'b0;
            bus_reqack = 1'b0;
        end
    end

    assign bus_respcyc = !reset && (state == RD_RESP);
    assign bus_resp    = bus_respcyc ? mem_rdata : '0;
    assign bus_resptag = bus_respcyc ? tag : '0;
    assign busy        = !reset && (state != IDLE);

    mem_array #(
        .DATA_W (BUS_DATA_WIDTH),
        .ADDR_W (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (bus_req),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder against a word-array reference model.
module tb_mem_bus_responder;

    localparam int DW   = 64;
    localparam int TW   = 13;
    localparam int MW   = 4096;
    localparam int LAT  = 4;
    localparam int NBLK = MW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bus_reqcyc = 1'b0;
    logic [DW-1:0] bus_req = '0;
    logic [TW-1:0] bus_reqtag = '0;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack = 1'b0;
    logic          busy;

    always #5 clk = ~clk;

    mem_bus_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .MEM_WORDS      (MW),
        .RD_LATENCY     (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] ref_mem [MW];
    logic [63:0] wbuf [8];
    logic [63:0] rbuf [8];

    int w_acks, w_bad, w_resp, w_wait, w_to;
    int r_lat, r_n, r_tagbad, r_unstable, r_bubbles, r_tail, r_busy, r_wait, r_to;

    function automatic int blk_of(input logic [63:0] a);
        return int'((a >> 6) % NBLK);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [63:0] addr, input int nwords);
        for (int b = 0; b < nwords; b++) ref_mem[blk_of(addr) * 8 + b] = wbuf[b];
    endtask

    // Drives one write; stop_after >= 0 returns right after that data beat.
    task automatic do_write(input logic [63:0] addr, input logic [TW-1:0] tag,
                            input logic [7:0] gap_after, input int stop_after);
        w_acks = 0; w_bad = 0; w_resp = 0; w_wait = 0; w_to = 1;
        bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus_respcyc) w_resp++;
            if (bus_reqack) begin
                w_acks++; w_to = 0; cyc(); break;
            end
            w_wait++;
            cyc();
        end
        if (w_to != 0) begin
            bus_reqcyc = 1'b0;
            return;
        end
        for (int b = 0; b < 8; b++) begin
            bus_reqcyc = 1'b1; bus_req = wbuf[b];
            #1;
            if (bus_reqack) w_acks++; else w_bad++;
            if (bus_respcyc) w_resp++;
            cyc();
            if (b == stop_after) return;
            if (gap_after[b]) begin
                bus_reqcyc = 1'b0; bus_req = {$urandom, $urandom};
                #1;
                if (bus_reqack) w_bad++;
                if (bus_respcyc) w_resp++;
                cyc();
            end
        end
        bus_reqcyc = 1'b0;
    endtask

    // mode 0: respack always high, 1: pattern 1,0,0,..., 2: random
    task automatic do_read(input logic [63:0] addr, input logic [TW-1:0] tag, input int mode);
        bit          prev_hold;
        logic [63:0] prev_data;
        r_lat = -1; r_n = 0; r_tagbad = 0; r_unstable = 0; r_bubbles = 0;
        r_tail = 0; r_busy = 0; r_wait = 0; r_to = 1;
        prev_hold = 1'b0; prev_data = '0;
        bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag; bus_respack = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus_reqack) begin
                r_to = 0; cyc(); break;
            end
            r_wait++;
            cyc();
        end
        bus_reqcyc = 1'b0;
        if (r_to != 0) return;
        r_to = 1;
        for (int k = 1; k < 300; k++) begin
            if (mode == 0)      bus_respack = 1'b1;
            else if (mode == 1) bus_respack = (k % 3 == 1);
            else                bus_respack = 1'($urandom_range(0, 1));
            #1;
            if (bus_respcyc) begin
                if (r_lat < 0) r_lat = k;
                if (bus_resptag !== tag) r_tagbad++;
                if (prev_hold && bus_resp !== prev_data) r_unstable++;
                if (bus_respack) begin
                    rbuf[r_n] = bus_resp;
                    r_n++;
                end
            end else begin
                if (r_n > 0) r_bubbles++;
                if (prev_hold) r_unstable++;
            end
            prev_hold = bus_respcyc && !bus_respack;
            prev_data = bus_resp;
            cyc();
            if (r_n == 8) begin
                r_to = 0; break;
            end
        end
        bus_respack = 1'b0;
        #1;
        r_tail = int'(bus_respcyc);
        r_busy = int'(busy);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc();
        bus_reqcyc = 1'b1; bus_req = 64'h1000; bus_reqtag = 13'h0001; bus_respack = 1'b1;
        #1;
        n_tests++; if (bus_reqack !== 1'b0) begin n_fail++; $display("FAIL reset_reqack: got %b need 0", bus_reqack); end
        n_tests++; if (bus_respcyc !== 1'b0) begin n_fail++; $display("FAIL reset_respcyc: got %b need 0", bus_respcyc); end
        n_tests++; if (bus_resp !== '0) begin n_fail++; $display("FAIL reset_resp: got %h need 0", bus_resp); end
        n_tests++; if (bus_resptag !== '0) begin n_fail++; $display("FAIL reset_resptag: got %h need 0", bus_resptag); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
        cyc();
        reset = 1'b0; bus_reqcyc = 1'b0; bus_respack = 1'b0;
        cyc();
    endtask

    task automatic test_write_basic();
        for (int b = 0; b < 8; b++) wbuf[b] = 64'h11 * (b + 1);
        do_write(64'h1000, 13'h1000, 8'h00, -1);
        model_write(64'h1000, 8);
        n_tests++; if (w_acks != 9) begin n_fail++; $display("FAIL wr_basic_acks: got %0d need 9", w_acks); end
        n_tests++; if (w_bad != 0) begin n_fail++; $display("FAIL wr_basic_badack: got %0d need 0", w_bad); end
        n_tests++; if (w_resp != 0) begin n_fail++; $display("FAIL wr_basic_respcyc: got %0d need 0", w_resp); end
        #1;
        n_tests++; if (busy !== 1'b0 || bus_respcyc !== 1'b0) begin n_fail++; $display("FAIL wr_basic_idle: got busy=%b respcyc=%b need 0 0", busy, bus_respcyc); end
        cyc();
    endtask

    task automatic test_read_basic();
        do_read(64'h1000, 13'h0005, 0);
        n_tests++; if (r_to != 0) begin n_fail++; $display("FAIL rd_basic_timeout: got %0d beats need 8", r_n); end
        n_tests++; if (r_lat != LAT) begin n_fail++; $display("FAIL rd_basic_latency: got %0d need %0d", r_lat, LAT); end
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (rbuf[i] !== 64'h11 * (i + 1)) begin n_fail++; $display("FAIL rd_basic_beat%0d: got %h need %h", i, rbuf[i], 64'h11 * (i + 1)); end
        end
        n_tests++; if (r_tagbad != 0) begin n_fail++; $display("FAIL rd_basic_tag: got %0d bad beats need 0", r_tagbad); end
        n_tests++; if (r_bubbles != 0) begin n_fail++; $display("FAIL rd_basic_bubble: got %0d need 0", r_bubbles); end
        n_tests++; if (r_tail != 0 || r_busy != 0) begin n_fail++; $display("FAIL rd_basic_tail: got respcyc=%0d busy=%0d need 0 0", r_tail, r_busy); end
        cyc();
    endtask

    task automatic test_read_offset();
        logic [TW-1:0] t;
        t = {1'b0, 12'($urandom)};
        do_read(64'h1028, t, 0);
        n_tests++; if (r_to != 0 || r_lat != LAT) begin n_fail++; $display("FAIL rd_ofs_timing: got lat=%0d beats=%0d need %0d 8", r_lat, r_n, LAT); end
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (rbuf[i] !== ref_mem[blk_of(64'h1000) * 8 + i]) begin n_fail++; $display("FAIL rd_ofs_beat%0d: got %h need %h", i, rbuf[i], ref_mem[blk_of(64'h1000) * 8 + i]); end
        end
        n_tests++; if (r_tagbad != 0) begin n_fail++; $display("FAIL rd_ofs_tag: got %0d bad beats need 0", r_tagbad); end
        cyc();
    endtask

    task automatic test_stall();
        do_read(64'h1000, 13'h0ABC, 1);
        n_tests++; if (r_to != 0) begin n_fail++; $display("FAIL stall_timeout: got %0d beats need 8", r_n); end
        n_tests++; if (r_unstable != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes need 0", r_unstable); end
        n_tests++; if (r_lat != LAT) begin n_fail++; $display("FAIL stall_latency: got %0d need %0d", r_lat, LAT); end
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (rbuf[i] !== ref_mem[blk_of(64'h1000) * 8 + i]) begin n_fail++; $display("FAIL stall_beat%0d: got %h need %h", i, rbuf[i], ref_mem[blk_of(64'h1000) * 8 + i]); end
        end
        n_tests++; if (r_tail != 0) begin n_fail++; $display("FAIL stall_tail: got %0d need 0", r_tail); end
        cyc();
    endtask

    task automatic test_write_gaps();
        logic [63:0] a;
        a = 64'(6'($urandom));
        for (int b = 0; b < 8; b++) wbuf[b] = {$urandom, $urandom};
        do_write(a, 13'h1000 | 13'($urandom_range(0, 4095)), 8'b0010_0100, -1);
        model_write(a, 8);
        n_tests++; if (w_acks != 9) begin n_fail++; $display("FAIL gaps_acks: got %0d need 9", w_acks); end
        n_tests++; if (w_bad != 0) begin n_fail++; $display("FAIL gaps_badack: got %0d need 0", w_bad); end
        cyc();
        do_read(64'h0, 13'h0077, 2);
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (rbuf[i] !== ref_mem[i]) begin n_fail++; $display("FAIL gaps_beat%0d: got %h need %h", i, rbuf[i], ref_mem[i]); end
        end
        n_tests++; if (r_unstable != 0 || r_bubbles != 0) begin n_fail++; $display("FAIL gaps_readback: got unstable=%0d bubbles=%0d need 0 0", r_unstable, r_bubbles); end
        cyc();
    endtask

    task automatic test_wrap();
        for (int b = 0; b < 8; b++) wbuf[b] = {$urandom, $urandom};
        do_write(64'hFFFF_FFFF_FFFF_FFC0, 13'h1FFF, 8'h00, -1);
        model_write(64'hFFFF_FFFF_FFFF_FFC0, 8);
        cyc();
        do_read(64'h0000_0001_0000_7FD5, 13'h0123, 0);
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (rbuf[i] !== ref_mem[(NBLK - 1) * 8 + i]) begin n_fail++; $display("FAIL wrap_beat%0d: got %h need %h", i, rbuf[i], ref_mem[(NBLK - 1) * 8 + i]); end
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 8; b++) wbuf[b] = {$urandom, $urandom};
        do_write(64'h2_0040, 13'h1001, 8'h00, -1);
        model_write(64'h2_0040, 8);
        do_read(64'h2_0040, 13'h0002, 0);
        n_tests++; if (r_wait != 1) begin n_fail++; $display("FAIL b2b_wr_rd_wait: got %0d need 1", r_wait); end
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (rbuf[i] !== ref_mem[blk_of(64'h2_0040) * 8 + i]) begin n_fail++; $display("FAIL b2b_beat%0d: got %h need %h", i, rbuf[i], ref_mem[blk_of(64'h2_0040) * 8 + i]); end
        end
        do_read(64'h1000, 13'h0003, 0);
        n_tests++; if (r_wait != 1) begin n_fail++; $display("FAIL b2b_rd_rd_wait: got %0d need 1", r_wait); end
        n_tests++; if (rbuf[7] !== ref_mem[blk_of(64'h1000) * 8 + 7]) begin n_fail++; $display("FAIL b2b_rd2_last: got %h need %h", rbuf[7], ref_mem[blk_of(64'h1000) * 8 + 7]); end
        cyc();
    endtask

    task automatic test_abort_reset();
        for (int b = 0; b < 8; b++) wbuf[b] = {$urandom, $urandom};
        do_write(64'h1000, 13'h1444, 8'h00, 2);
        model_write(64'h1000, 3);
        bus_reqcyc = 1'b1; bus_req = wbuf[3]; reset = 1'b1;
        #1;
        n_tests++; if (bus_reqack !== 1'b0 || busy !== 1'b0 || bus_respcyc !== 1'b0) begin n_fail++; $display("FAIL abort_in_reset: got ack=%b busy=%b respcyc=%b need 0 0 0", bus_reqack, busy, bus_respcyc); end
        cyc();
        reset = 1'b0; bus_reqcyc = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0 || bus_resp !== '0 || bus_resptag !== '0) begin n_fail++; $display("FAIL abort_after_reset: got busy=%b resp=%h tag=%h need 0 0 0", busy, bus_resp, bus_resptag); end
        cyc();
        do_read(64'h1000, 13'h0009, 2);
        n_tests++; if (r_to != 0) begin n_fail++; $display("FAIL abort_read_timeout: got %0d beats need 8", r_n); end
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (rbuf[i] !== ref_mem[blk_of(64'h1000) * 8 + i]) begin n_fail++; $display("FAIL abort_beat%0d: got %h need %h", i, rbuf[i], ref_mem[blk_of(64'h1000) * 8 + i]); end
        end
        cyc();
    endtask

    task automatic test_random();
        logic [63:0] a, alias_a;
        for (int t = 0; t < 5; t++) begin
            a = {$urandom, $urandom};
            for (int b = 0; b < 8; b++) wbuf[b] = {$urandom, $urandom};
            do_write(a, 13'h1000 | 13'($urandom_range(0, 4095)), 8'($urandom), -1);
            model_write(a, 8);
            n_tests++; if (w_acks != 9 || w_bad != 0) begin n_fail++; $display("FAIL rand%0d_wr: got acks=%0d bad=%0d need 9 0", t, w_acks, w_bad); end
            cyc();
            alias_a = ({$urandom, $urandom} & ~64'h7FFF) | (64'(blk_of(a)) << 6) | 64'(6'($urandom));
            do_read(alias_a, {1'b0, 12'($urandom)}, 2);
            n_tests++; if (r_lat != LAT || r_unstable != 0 || r_bubbles != 0 || r_tagbad != 0) begin
                n_fail++; $display("FAIL rand%0d_rd_proto: got lat=%0d unstable=%0d bubbles=%0d tagbad=%0d need %0d 0 0 0", t, r_lat, r_unstable, r_bubbles, r_tagbad, LAT);
            end
            for (int i = 0; i < 8; i++) begin
                n_tests++; if (rbuf[i] !== ref_mem[blk_of(a) * 8 + i]) begin n_fail++; $display("FAIL rand%0d_beat%0d: got %h need %h", t, i, rbuf[i], ref_mem[blk_of(a) * 8 + i]); end
            end
            cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < MW; i++) ref_mem[i] = '0;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_read_offset();
        test_stall();
        test_write_gaps();
        test_wrap();
        test_back_to_back();
        test_abort_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running need finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, bus data width.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, tag width.
REQ-003 SHALL have parameter MEM_WORDS, default 4096, backing-store depth in 64-bit words; power of two.
REQ-004 SHALL have parameter RD_LATENCY, default 4, cycles from read accept to first response beat; legal range 1..15.
REQ-005 clk  input  1  clock; all state changes on posedge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 bus_reqcyc  input  1  requester drives a valid address or data beat.
REQ-008 bus_req  input  BUS_DATA_WIDTH  address beat (byte address), or write-data beat.
REQ-009 bus_reqtag  input  BUS_TAG_WIDTH  request tag; bit 12 = 1 write, 0 read.
REQ-010 bus_reqack  output  1  one-cycle acceptance of the current request beat.
REQ-011 bus_respcyc  output  1  response beat valid.
REQ-012 bus_resp  output  BUS_DATA_WIDTH  response data word.
REQ-013 bus_resptag  output  BUS_TAG_WIDTH  echo of the captured request tag.
REQ-014 bus_respack  input  1  requester consumed the current response beat.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WR_DATA, RD_WAIT, RD_RESP.
REQ-017 IDLE, bus_reqcyc=1: SHALL pulse bus_reqack for one cycle, capture tag and block index = bus_req[63:6] mod (MEM_WORDS/8), and clear the 3-bit beat counter; address bits [5:0] are ignored.
REQ-018 IDLE accept with tag[12]=1 SHALL enter WR_DATA; with tag[12]=0 SHALL enter RD_WAIT and load the latency counter with RD_LATENCY.
REQ-019 WR_DATA: each cycle with bus_reqcyc=1 SHALL write bus_req to word (block*8 + beat), pulse bus_reqack, and increment beat; beat 7 SHALL return to IDLE; cycles with bus_reqcyc=0 SHALL hold state with no write.
REQ-020 Writes SHALL produce no response beats.
REQ-021 RD_WAIT SHALL decrement the latency counter each cycle and enter RD_RESP when it reaches 1, so the first bus_respcyc is asserted exactly RD_LATENCY cycles after the reqack cycle.
REQ-022 RD_RESP SHALL drive bus_respcyc=1, bus_resp = word (block*8 + beat), bus_resptag = captured tag, holding all three stable until bus_respack=1.
REQ-023 On bus_respack=1 in RD_RESP, beat SHALL increment and the next word SHALL appear in the following cycle with no bubble; respack on beat 7 SHALL deassert bus_respcyc next cycle and return to IDLE.
REQ-024 Beats SHALL be delivered in ascending word order 0..7 within the block; there is no critical-word-first ordering.
REQ-025 A new request SHALL NOT be accepted in the cycle the FSM returns to IDLE; earliest accept is the following cycle, and bus_reqack SHALL be 0 outside IDLE-accept and WR_DATA beats.
REQ-026 bus_respack while bus_respcyc=0 SHALL be ignored.
REQ-027 Block index SHALL wrap modulo MEM_WORDS/8; no out-of-range error exists.
REQ-028 Read-after-write to the same block SHALL return the newly written data.

Reset
REQ-029 Reset SHALL force IDLE, bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0, busy=0, and beat and latency counters to 0.
REQ-030 Reset mid-transfer SHALL abandon the transfer; words already written SHALL persist, and remaining beats SHALL NOT be written.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-032 Package sysbus_pkg SHALL hold the tag write-bit index (12), BEATS_PER_BLOCK (8), the block-offset width (6), and the state enum.
REQ-033 Storage SHALL be a sub-module mem_array: single-port 64-bit synchronous RAM with one-cycle read latency; the top FSM pre-issues reads to meet REQ-023.

Verification
REQ-034 Write 0x1000, tag 0x1000, data 0x11..0x88 with reqcyc continuously high -> 9 reqack pulses, returns to IDLE, no respcyc.
REQ-035 Read 0x1000, tag 0x0005, respack held high, RD_LATENCY=4 -> first respcyc 4 cycles after reqack; beats 0x11..0x88 on consecutive cycles; resptag=0x0005.
REQ-036 Read 0x1028 -> same 8 words as a read of 0x1000, in order 0..7 (REQ-017).
REQ-037 Read with respack toggling 1,0,0,1,... -> each beat held stable through stall cycles; no beat duplicated or dropped.
REQ-038 Write to block 0 with reqcyc gaps after beats 2 and 5 -> all 8 words stored; reqack only on cycles with reqcyc=1.
REQ-039 Reset asserted after write beat 3, then read the same block -> words 0..2 new, words 3..7 old; FSM in IDLE with outputs at reset values after reset.
